// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared types and default sizes for the scoreboarded register file
package regfile_sb_pkg;

    localparam int DefWidth = 16;
    localparam int DefDepth = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sweepState_e;

endpackage

// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - sequential clear sweep: one register per cycle, ready low while sweeping
module regfile_sweep
    import regfile_sb_pkg::*;
#(
    parameter int DEPTH = DefDepth,
    parameter int SELW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            ready,
    output logic            done,
    output logic            sweepEn,
    output logic [SELW-1:0] sweepIdx
);

    localparam logic [SELW-1:0] LastIdx = SELW'(DEPTH - 1);

    sweepState_e     state, stateNext;
    logic [SELW-1:0] cnt, cntNext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ready     = 1'b1;
        done      = 1'b0;
        sweepEn   = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                end
            end
            CLEAR: begin
                ready   = 1'b0;
                sweepEn = 1'b1;
                cntNext = cnt + 1'b1;
                if (cnt == LastIdx) begin
                    stateNext = IDLE;
                    // a reset landing on the final cycle aborts the sweep, so no pulse
                    done      = rst;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign sweepIdx = cnt;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy bits and clear sweep
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH   = DefWidth,
    parameter int DEPTH   = DefDepth,
    parameter int SELW    = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [SELW-1:0]  selRd,
    input  logic [WIDTH-1:0] rd,
    input  logic [SELW-1:0]  selRs,
    input  logic [SELW-1:0]  selRt,
    output logic [WIDTH-1:0] rs,
    output logic [WIDTH-1:0] rt,
    input  logic             iss,
    input  logic [SELW-1:0]  selIss,
    output logic             busyRs,
    output logic             busyRt,
    input  logic             clr,
    output logic             ready,
    output logic             done
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             sweepEn;
    logic [SELW-1:0]  sweepIdx;
    logic             writeOk;
    logic             issueOk;

    regfile_sweep #(
        .DEPTH (DEPTH),
        .SELW  (SELW)
    ) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ready    (ready),
        .done     (done),
        .sweepEn  (sweepEn),
        .sweepIdx (sweepIdx)
    );

    // register 0 is never written nor issued when hardwired, so it stays zero and idle
    assign writeOk = ready && wen && !((ZERO_R0 != 0) && (selRd == '0));
    assign issueOk = ready && iss && !((ZERO_R0 != 0) && (selIss == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            if (writeOk) begin
                regs[selRd] <= rd;
                busy[selRd] <= 1'b0;
            end
            // issue is applied after the write so a same-index collision leaves busy set
            if (issueOk) begin
                busy[selIss] <= 1'b1;
            end
            if (sweepEn) begin
                regs[sweepIdx] <= '0;
                busy[sweepIdx] <= 1'b0;
            end
        end
    end

    always_comb begin
        rs     = regs[selRs];
        rt     = regs[selRt];
        busyRs = busy[selRs];
        busyRt = busy[selRt];
`ifdef REGFILE_BYPASS_EN
        if (writeOk && (selRd == selRs)) begin
            rs     = rd;
            busyRs = issueOk && (selIss == selRs);
        end
        if (writeOk && (selRd == selRt)) begin
            rt     = rd;
            busyRt = issueOk && (selIss == selRt);
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int W = 16;
    localparam int D = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wen = 1'b0;
    logic         iss = 1'b0;
    logic         clr = 1'b0;
    logic [S-1:0] selRd = '0, selRs = '0, selRt = '0, selIss = '0;
    logic [W-1:0] rd = '0;
    logic [W-1:0] rs, rt;
    logic         busyRs, busyRt, ready, done;

    int nChecks = 0;
    int nPass   = 0;

    regfile_sb #(
        .WIDTH   (W),
        .DEPTH   (D),
        .SELW    (S),
        .ZERO_R0 (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .selRd  (selRd),
        .rd     (rd),
        .selRs  (selRs),
        .selRt  (selRt),
        .rs     (rs),
        .rt     (rt),
        .iss    (iss),
        .selIss (selIss),
        .busyRs (busyRs),
        .busyRt (busyRt),
        .clr    (clr),
        .ready  (ready),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input int idx, input logic [W-1:0] val);
        selRd = S'(idx);
        rd    = val;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
    endtask

    initial begin
        int readyLow;
        int doneCnt;
        int doneAt;
        logic [W-1:0] expR2;

        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rs", 32'(rs), 32'h0);
        check("reset_busy", 32'(busyRs), 32'd0);

        writeReg(3, 16'h1234);
        selRs = 4'd3;
        #1;
        check("r3_data", 32'(rs), 32'h1234);
        check("r3_busy", 32'(busyRs), 32'd0);

        selIss = 4'd5;
        iss    = 1'b1;
        tick();
        iss    = 1'b0;
        selRt  = 4'd5;
        #1;
        check("r5_busy_set", 32'(busyRt), 32'd1);
        writeReg(5, 16'hBEEF);
        #1;
        check("r5_busy_clr", 32'(busyRt), 32'd0);
        check("r5_data", 32'(rt), 32'hBEEF);

        selIss = 4'd7;
        iss    = 1'b1;
        writeReg(7, 16'h7777);
        iss    = 1'b0;
        selRs  = 4'd7;
        #1;
        check("r7_data", 32'(rs), 32'h7777);
        check("r7_busy_wins", 32'(busyRs), 32'd1);

        writeReg(2, 16'h0F0F);
        selRs = 4'd2;
        selRd = 4'd2;
        rd    = 16'hA5A5;
        wen   = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        expR2 = 16'hA5A5;
`else
        expR2 = 16'h0F0F;
`endif
        check("r2_same_cycle", 32'(rs), 32'(expR2));
        check("r2_same_busy", 32'(busyRs), 32'd0);
        tick();
        wen = 1'b0;
        #1;
        check("r2_next_cycle", 32'(rs), 32'hA5A5);

        rst = 1'b0;
        selRd = 4'd4;
        rd    = 16'h4444;
        wen   = 1'b1;
        selIss = 4'd4;
        iss   = 1'b1;
        tick();
        rst = 1'b1;
        wen = 1'b0;
        iss = 1'b0;
        selRs = 4'd4;
        #1;
        check("rst_blocks_wen", 32'(rs), 32'h0);
        check("rst_blocks_iss", 32'(busyRs), 32'd0);
        selRs = 4'd7;
        #1;
        check("rst_clears_r7", 32'(rs), 32'h0);

        for (int i = 0; i < D; i++) writeReg(i, 16'h0100 + 16'(i));
        selRs = 4'd9;
        #1;
        check("fill_r9", 32'(rs), 32'h0109);

        // clr together with a write: write lands, sweep clears it later
        selRs = 4'd15;
        selRt = 4'd14;
        clr   = 1'b1;
        selRd = 4'd15;
        rd    = 16'hF00D;
        wen   = 1'b1;
        tick();
        clr = 1'b0;
        wen = 1'b0;
        #1;
        check("sweep_r15_written", 32'(rs), 32'hF00D);
        check("sweep_r14_old", 32'(rt), 32'h010E);

        readyLow = 0;
        doneCnt  = 0;
        doneAt   = -1;
        for (int j = 0; j < 20; j++) begin
            if (!ready) readyLow++;
            if (done) begin
                doneCnt++;
                doneAt = j;
            end
            if (j == 3) begin
                selRd = 4'd0;
                rd    = 16'hDEAD;
                wen   = 1'b1;
                iss   = 1'b1;
                selIss = 4'd0;
                clr   = 1'b1;
            end else begin
                wen = 1'b0;
                iss = 1'b0;
                clr = 1'b0;
            end
            tick();
        end
        check("sweep_ready_low", 32'(readyLow), 32'd16);
        check("sweep_done_cnt", 32'(doneCnt), 32'd1);
        check("sweep_done_at", 32'(doneAt), 32'd15);
        check("sweep_ready_end", 32'(ready), 32'd1);
        for (int i = 0; i < D; i++) begin
            selRs = S'(i);
            #1;
            check($sformatf("sweep_zero_r%0d", i), 32'({busyRs, rs}), 32'h0);
        end

        writeReg(9, 16'h9999);
        writeReg(14, 16'hEEEE);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        doneCnt = 0;
        for (int j = 0; j < 6; j++) begin
            if (done) doneCnt++;
            tick();
        end
        rst = 1'b0;
        #1;
        if (done) doneCnt++;
        tick();
        rst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (done) doneCnt++;
            tick();
        end
        check("abort_no_done", 32'(doneCnt), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        selRs = 4'd9;
        selRt = 4'd14;
        #1;
        check("abort_r9", 32'(rs), 32'h0);
        check("abort_r14", 32'(rt), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
